// File: rtl/frac_mul_seq.sv
// frac_mul_seq: sequential shift-add multiplier, unsigned Q0.N fraction times
// unsigned N-bit integer. Scales a WFQ divider ratio back by an integer weight.
//
// State table:
//   IDLE | waiting for operands, in_ready=1
//   BUSY | N shift-add iterations in progress
//   DONE | result presented, out_valid=1, waiting for out_ready
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready depends on state only)
//   frac               fraction operand, value frac/2^N
//   mult               integer operand
//   out_valid/out_ready result handshake
//   product            exact frac*mult, Q N.N
//   result_int         floor(frac*mult/2^N)
//   result_rnd         result_int rounded half-up
module frac_mul_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   frac,
  input  logic [N-1:0]   mult,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   result_int,
  output logic [N-1:0]   result_rnd
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  m_reg;
  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [CW-1:0] cnt;
  logic [N:0]    a_sum;
  logic [2*N:0]  aq_shift;
  logic          accept;
  logic          last_iter;

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A carries one guard bit so the add never loses its carry before the shift.
  always_comb begin
    a_sum    = q_reg[0] ? ({1'b0, a_reg[N-1:0]} + {1'b0, m_reg}) : a_reg;
    aq_shift = {a_sum, q_reg} >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (state == IDLE && accept) begin
        m_reg <= mult;
        q_reg <= frac;
        a_reg <= '0;
        cnt   <= CW'(N - 1);
      end else if (state == BUSY) begin
        a_reg <= aq_shift[2*N:N];
        q_reg <= aq_shift[N-1:0];
        cnt   <= cnt - 1'b1;
        if (last_iter) product <= aq_shift[2*N-1:0];
      end
    end
  end

  // result_int <= mult-1 for any Q0.N fraction, so the increment cannot wrap.
  assign result_int = product[2*N-1:N];
  assign result_rnd = result_int + {{(N-1){1'b0}}, product[N-1]};

endmodule

// File: tb/tb_frac_mul_seq.sv
// Directed and randomized bench for frac_mul_seq (N=16).
module tb_frac_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] frac;
  logic [15:0] mult;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic [15:0] result_int;
  logic [15:0] result_rnd;

  int checks   = 0;
  int failures = 0;

  frac_mul_seq #(.N(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frac       (frac),
    .mult       (mult),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .result_int (result_int),
    .result_rnd (result_rnd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, count latency, optional backpressure with
  // input noise, drain, then confirm idle and held outputs.
  task automatic do_op(input logic [15:0] f, input logic [15:0] m,
                       input logic [31:0] exp_p, input logic [15:0] exp_i,
                       input logic [15:0] exp_r, input int hold);
    int n;
    @(negedge clk);
    check_val("ready_before", {63'd0, in_ready}, 64'd1);
    frac = f; mult = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    frac = ~f; mult = ~m;
    n = 0;
    while (!out_valid && n < 40) begin
      check_val("ready_busy", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      n++;
    end
    check_val("latency", n, 16);
    check_val("product", product, exp_p);
    check_val("res_int", result_int, exp_i);
    check_val("res_rnd", result_rnd, exp_r);
    for (int i = 0; i < hold; i++) begin
      in_valid = $urandom_range(0, 1);
      frac = 16'($urandom); mult = 16'($urandom);
      @(negedge clk);
      check_val("bp_valid", {63'd0, out_valid}, 64'd1);
      check_val("bp_ready", {63'd0, in_ready}, 64'd0);
      check_val("bp_product", product, exp_p);
      check_val("bp_rnd", result_rnd, exp_r);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_val("drain_valid", {63'd0, out_valid}, 64'd0);
    check_val("drain_ready", {63'd0, in_ready}, 64'd1);
    check_val("hold_product", product, exp_p);
  endtask

  initial begin
    logic [31:0] p;
    logic [32:0] pr;
    logic [15:0] rf, rm;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; frac = '0; mult = '0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_product", product, 64'd0);
    check_val("rst_rnd", result_rnd, 64'd0);
    rst = 1'b0;

    do_op(16'h8000, 16'd100,  32'h0032_0000, 16'd50,   16'd50,   0);
    do_op(16'h5555, 16'd3,    32'h0000_FFFF, 16'd0,    16'd1,    0);
    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16'hFFFE, 16'hFFFE, 0);
    do_op(16'h0000, 16'h1234, 32'h0000_0000, 16'd0,    16'd0,    0);
    do_op(16'hC000, 16'd5,    32'h0003_C000, 16'd3,    16'd4,    5);
    do_op(16'h1234, 16'h0000, 32'h0000_0000, 16'd0,    16'd0,    2);

    // Reset mid-operation, asserted between edges.
    @(negedge clk);
    frac = 16'h4000; mult = 16'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", {63'd0, out_valid}, 64'd0);
    check_val("arst_ready", {63'd0, in_ready}, 64'd1);
    check_val("arst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("no_stale", {63'd0, out_valid}, 64'd0);
    end
    out_ready = 1'b0;
    do_op(16'h4000, 16'd8, 32'h0002_0000, 16'd2, 16'd2, 0);

    // Randomized operands with random idle gaps and backpressure.
    for (int k = 0; k < 200; k++) begin
      rf = 16'($urandom);
      rm = 16'($urandom);
      if (k % 17 == 0) rf = 16'hFFFF;
      p  = 32'(rf) * 32'(rm);
      pr = {1'b0, p} + 33'h8000;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(rf, rm, p, p[31:16], pr[31:16], $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
